vc_fifo: RTL

//   Multi-channel successor of the single-queue router FIFO: NUM_VC independent queues, one write port and
//   one read port, each carrying a VC select. Sits at router input ports so flits of different virtual

---
 rtl/vc_fifo_pkg.sv | 22 ++
 rtl/vc_fifo_queue.sv | 73 +++++++
 rtl/vc_fifo.sv | 83 ++++++++
 3 files changed

// File: rtl/vc_fifo_pkg.sv
// Shared types and defaults for the multi-VC router input FIFO.
package vc_fifo_pkg;

  localparam int DEF_SIZE       = 8;
  localparam int DEF_DEPTH_LOG2 = 4;
  localparam int DEF_NUM_VC     = 2;
  localparam int DEF_VC_BITS    = 1;
  localparam int DEF_AF_LEVEL   = 12;

  // Operation applied to one queue in a given cycle, encoded as {push, pop}.
  typedef enum logic [1:0] {
    Q_IDLE     = 2'b00,
    Q_POP      = 2'b01,
    Q_PUSH     = 2'b10,
    Q_PUSH_POP = 2'b11
  } q_op_e;

  function automatic q_op_e q_op(input logic push, input logic pop);
    return q_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/vc_fifo_queue.sv
// One virtual-channel queue: circular buffer with registered count and flags.
// push/pop arrive already qualified by the parent, so they are never illegal here.
module vc_fifo_queue
  import vc_fifo_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int AF_LEVEL   = DEF_AF_LEVEL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [SIZE-1:0]       din,
  output logic [SIZE-1:0]       head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [SIZE-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  full_q;
  logic                  empty_q;

  // Next occupancy: a simultaneous push and pop leave the count unchanged.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    unique case (q_op(push, pop))
      Q_PUSH:  cnt_d = cnt_q + CW'(1);
      Q_POP:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers, count and flags; full/empty are registered with the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: storage is cleared on reset so the show-ahead head reads 0 afterwards.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  assign head        = mem[rd_ptr];
  assign count       = cnt_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = (cnt_q >= CW'(AF_LEVEL));

endmodule

// File: rtl/vc_fifo.sv
// Multi-VC router input FIFO: NUM_VC independent queues sharing one write and
// one read port. Decodes VC selects, qualifies requests, muxes the head flit,
// packs per-VC counts and holds the sticky overflow/underflow flags.
module vc_fifo
  import vc_fifo_pkg::*;
#(
  parameter int ID         = -1,
  parameter int SIZE       = DEF_SIZE,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int NUM_VC     = DEF_NUM_VC,
  parameter int VC_BITS    = DEF_VC_BITS,
  parameter int AF_LEVEL   = DEF_AF_LEVEL
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             write,
  input  logic [VC_BITS-1:0]               write_vc,
  input  logic [SIZE-1:0]                  item_in,
  input  logic                             read,
  input  logic [VC_BITS-1:0]               read_vc,
  output logic [SIZE-1:0]                  item_out,
  output logic [NUM_VC-1:0]                full,
  output logic [NUM_VC-1:0]                empty,
  output logic [NUM_VC-1:0]                almost_full,
  output logic [NUM_VC*(DEPTH_LOG2+1)-1:0] count,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int CW = DEPTH_LOG2 + 1;

  logic [NUM_VC-1:0] wr_sel;
  logic [NUM_VC-1:0] rd_sel;
  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] pop;
  logic [SIZE-1:0]   head [NUM_VC];

  // A select value >= NUM_VC matches no queue, so such requests are rejected.
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign wr_sel[v] = write && (write_vc == VC_BITS'(v));
    assign rd_sel[v] = read  && (read_vc  == VC_BITS'(v));
    assign pop[v]    = rd_sel[v] && !empty[v];
    // A full queue still accepts a push when the same edge pops it.
    assign push[v]   = wr_sel[v] && (!full[v] || pop[v]);

    vc_fifo_queue #(
      .SIZE       (SIZE),
      .DEPTH_LOG2 (DEPTH_LOG2),
      .AF_LEVEL   (AF_LEVEL)
    ) u_queue (
      .clk         (clk),
      .reset       (reset),
      .push        (push[v]),
      .pop         (pop[v]),
      .din         (item_in),
      .head        (head[v]),
      .count       (count[v*CW +: CW]),
      .full        (full[v]),
      .empty       (empty[v]),
      .almost_full (almost_full[v])
    );
  end

  // Show-ahead output: head of the selected queue, zero for an unused select.
  always_comb begin
    item_out = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (read_vc == VC_BITS'(v)) item_out = head[v];
    end
  end

  // Sticky error flags: any rejected request sets them until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write && !(|push)) overflow  <= 1'b1;
      if (read  && !(|pop))  underflow <= 1'b1;
    end
  end

endmodule
